// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter: round-robin grant of one of NUM_OUTPUTS requesters, emitted as a binary select for the demux.
// Latency: request in IDLE -> o_valid at next edge; i_done -> o_valid low at next edge; at least one IDLE cycle between grants.
// Backpressure: grant is held until i_done (or forced release when ARB_TIMEOUT_EN is defined); requests are ignored while granted.
module rr_select_arbiter #(
  parameter int NUM_OUTPUTS = 5,
  parameter int SEL_W       = $clog2(NUM_OUTPUTS),
  parameter int MAX_HOLD    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_OUTPUTS-1:0] i_req,
  input  logic                   i_done,
  output logic [SEL_W-1:0]       o_select,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_inc;
  logic [SEL_W-1:0] win_idx;
  logic             load_sel;
  logic             rel;
  logic             hold_hit;

  if (NUM_OUTPUTS < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_select_arbiter: NUM_OUTPUTS must be >= 2 and MAX_HOLD >= 1");
  end

  // Scan offsets from high to low so the smallest offset from ptr wins; idx stays below NUM_OUTPUTS.
  always_comb begin : winner
    int                   idx;
    logic [NUM_OUTPUTS-1:0] req_shift;
    win_idx   = ptr;
    idx       = 0;
    req_shift = '0;
    for (int off = NUM_OUTPUTS - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_OUTPUTS) idx = idx - NUM_OUTPUTS;
      req_shift = i_req >> idx;
      if (req_shift[0]) win_idx = idx[SEL_W-1:0];
    end
  end

  assign ptr_inc = (o_select == SEL_W'(NUM_OUTPUTS - 1)) ? '0 : o_select + SEL_W'(1);

  always_comb begin
    state_nxt = state;
    load_sel  = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_nxt = GRANT;
          load_sel  = 1'b1;
        end
      end
      GRANT: begin
        if (i_done || hold_hit) begin
          state_nxt = IDLE;
          rel       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      o_select <= '0;
      ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (load_sel) o_select <= win_idx;
      if (rel)      ptr      <= ptr_inc;
    end
  end

  assign o_valid = (state == GRANT);
  assign o_busy  = o_valid;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // hold_cnt counts completed GRANT cycles, so the limit fires on the MAX_HOLD-th one.
  assign hold_hit = (state == GRANT) && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= hold_hit && !i_done;
      if (load_sel)           hold_cnt <= '0;
      else if (state == GRANT) hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  assign o_timeout = timeout_q;
`else
  assign hold_hit  = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter: a cycle-level grant model plus literal expectations at key points.
module tb_rr_select_arbiter;

  localparam int N     = 5;
  localparam int SEL_W = $clog2(N);
`ifdef ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 4;
  localparam bit TO_EN    = 1'b1;
`else
  localparam int MAX_HOLD = 16;
  localparam bit TO_EN    = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [N-1:0]     i_req;
  logic             i_done;
  logic [SEL_W-1:0] o_select;
  logic             o_valid;
  logic             o_busy;
  logic             o_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int m_valid, m_sel, m_ptr, m_age, m_to;

  rr_select_arbiter #(.NUM_OUTPUTS(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_done   (i_done),
    .o_select (o_select),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_timeout(o_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or after p, walking modulo N.
  function automatic int rr_pick(input logic [N-1:0] req, input int p);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) begin
      r = req >> ((p + k) % N);
      if (r[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0;
      m_sel   <= 0;
      m_ptr   <= 0;
      m_age   <= 0;
      m_to    <= 0;
    end else begin
      m_to <= 0;
      if (m_valid == 0) begin
        if (i_req != '0) begin
          m_valid <= 1;
          m_sel   <= rr_pick(i_req, m_ptr);
          m_age   <= 1;
        end
      end else if (i_done || (TO_EN && m_age == MAX_HOLD)) begin
        m_valid <= 0;
        m_ptr   <= (m_sel + 1) % N;
        m_to    <= (TO_EN && !i_done) ? 1 : 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("valid",   o_valid,   m_valid);
      chk("busy",    o_busy,    m_valid);
      chk("select",  o_select,  m_sel);
      chk("timeout", o_timeout, m_to);
    end
  end

  task automatic drive(input logic [N-1:0] req, input logic done);
    @(negedge clk);
    i_req  = req;
    i_done = done;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_now();
    i_req  = '0;
    i_done = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_select",  o_select,  0);
    chk("rst_valid",   o_valid,   0);
    chk("rst_busy",    o_busy,    0);
    chk("rst_timeout", o_timeout, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int rr_exp [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst    = 1'b1;
    i_req  = '0;
    i_done = 1'b0;
    #1;
    chk("init_valid",  o_valid,  0);
    chk("init_select", o_select, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single request
    drive(5'b00100, 1'b0); tick();
    chk("single_sel", o_select, 2);
    chk("single_vld", o_valid,  1);
    drive(5'b00000, 1'b1); tick();
    chk("single_rel_vld", o_valid,  0);
    chk("single_rel_sel", o_select, 2);
    chk("single_ptr",     m_ptr,    3);

    // round robin from pointer 0 with everything requesting
    drive(5'b00000, 1'b0);
    @(posedge clk); #2;
    reset_now();
    for (int g = 0; g < 6; g++) begin
      drive(5'b11111, 1'b0); tick();
      chk("rr_sel", o_select, rr_exp[g]);
      chk("rr_vld", o_valid,  1);
      drive(5'b11111, 1'b1); tick();
      chk("rr_idle", o_valid, 0);
    end
    chk("rr_ptr", m_ptr, 1);

    // wrap and priority
    drive(5'b01000, 1'b0); tick();
    chk("wrap_pre_sel", o_select, 3);
    drive(5'b00000, 1'b1); tick();
    chk("wrap_ptr", m_ptr, 4);
    drive(5'b00011, 1'b0); tick();
    chk("wrap_sel", o_select, 0);
    drive(5'b00000, 1'b1); tick();
    drive(5'b10010, 1'b0); tick();
    chk("prio_sel1", o_select, 1);
    drive(5'b10010, 1'b1); tick();
    drive(5'b10010, 1'b0); tick();
    chk("prio_sel4", o_select, 4);
    drive(5'b00000, 1'b1); tick();

    // hold stability against changing requests
    drive(5'b00010, 1'b0); tick();
    chk("hold_start", o_select, 1);
    repeat (10) begin
      drive(5'b00001, 1'b0); tick();
    end
    chk("hold_sel", o_select, 1);
    chk("hold_vld", o_valid,  1);
    drive(5'b00000, 1'b1); tick();
    chk("hold_rel", o_valid, 0);
    repeat (3) begin
      drive(5'b00000, 1'b1); tick();
    end
    chk("idle_done_vld", o_valid, 0);
    chk("idle_done_ptr", m_ptr,   2);
    drive(5'b11111, 1'b0); tick();
    chk("idle_done_sel", o_select, 2);

    // i_done together with requests: release, then arbitrate with the new pointer
    drive(5'b11111, 1'b1); tick();
    chk("done_req_rel", o_valid, 0);
    drive(5'b11111, 1'b0); tick();
    chk("done_req_sel", o_select, 3);
    chk("done_req_vld", o_valid,  1);

    // asynchronous reset mid-grant
    reset_now();
    drive(5'b11110, 1'b0); tick();
    chk("post_rst_sel", o_select, 1);

`ifdef ARB_TIMEOUT_EN
    repeat (3) begin
      drive(5'b00000, 1'b0); tick();
    end
    chk("to_still_vld", o_valid, 1);
    drive(5'b00000, 1'b0); tick();
    chk("to_drop_vld", o_valid,   0);
    chk("to_pulse",    o_timeout, 1);
    drive(5'b00000, 1'b0); tick();
    chk("to_pulse_end", o_timeout, 0);
    chk("to_ptr",       m_ptr,     2);
`else
    repeat (50) begin
      drive(5'b00000, 1'b0); tick();
    end
    chk("no_to_vld", o_valid,   1);
    chk("no_to_sel", o_select,  1);
    chk("no_to_out", o_timeout, 0);
`endif

    drive(5'b00000, 1'b1); tick();
    drive(5'b00000, 1'b0); tick();
    chk("end_idle", o_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
